// File: rtl/sd_pkg.sv
// Shared state encoding, error-bit positions and timer width for the SD
// data-transfer controller and its optional timeout counter.
package sd_pkg;

    localparam int TIMEOUT_W = 24;

    localparam int ERR_CRC     = 0;
    localparam int ERR_END_BIT = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_ABORT   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PAUSED,
        ST_DRAIN,
        ST_DONE
    } xfer_state_e;

endpackage

// File: rtl/sd_timeout_ctr.sv
// Saturating DAT timeout counter; exists only when SD_XFER_TIMEOUT_EN is
// defined, so a default build carries no timer logic at all.
`ifdef SD_XFER_TIMEOUT_EN
module sd_timeout_ctr
    import sd_pkg::*;
(
    input  logic                 sdclk_i,
    input  logic                 rst_dat_i,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 trigger_o
);

    logic [TIMEOUT_W-1:0] count_q;
    logic                 armed_q;
    logic                 hit;

    // The trigger is seen in the very cycle the count matches, and that same
    // edge disarms, so the pulse is always exactly one cycle wide.
    assign hit       = armed_q && (count_q == limit_i);
    assign trigger_o = hit;

    always_ff @(posedge sdclk_i or posedge rst_dat_i) begin
        if (rst_dat_i) begin
            count_q <= '0;
            armed_q <= 1'b0;
        end else if (start_i) begin
            count_q <= '0;
            armed_q <= 1'b1;
        end else if (clear_i || hit) begin
            armed_q <= 1'b0;
        end else if (armed_q && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/sd_xfer_ctrl.sv
// Multi-block SD DAT transfer sequencer: issues blocks, pauses at gaps,
// handles abort/drain. Optional timer built when SD_XFER_TIMEOUT_EN is defined.
module sd_xfer_ctrl
    import sd_pkg::*;
(
    input  logic                 sdclk_i,
    input  logic                 rst_dat_i,
    input  logic                 start_i,
    input  logic                 dir_write_i,
    input  logic [15:0]          block_count_i,
    input  logic                 stop_at_gap_i,
    input  logic                 continue_i,
    input  logic                 abort_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    output logic                 issue_read_o,
    output logic                 issue_write_o,
    input  logic                 transfer_complete_i,
    input  logic                 crc_error_i,
    input  logic                 end_bit_error_i,
    input  logic                 timeout_error_i,
    input  logic                 timeout_start_i,
    input  logic                 timeout_clear_i,
    output logic                 timeout_trigger_o,
    output logic                 busy_o,
    output logic                 paused_o,
    output logic                 done_o,
    output logic [15:0]          blocks_left_o,
    output logic [3:0]           err_o
);

    xfer_state_e state_q, state_d;
    logic [15:0] blocks_q, blocks_d;
    logic [3:0]  err_q, err_d;
    logic        dir_q, dir_d;
    logic        issue_q;
    logic [3:0]  status;

    always_ff @(posedge sdclk_i or posedge rst_dat_i) begin
        if (rst_dat_i) begin
            state_q  <= ST_IDLE;
            blocks_q <= '0;
            err_q    <= '0;
            dir_q    <= 1'b0;
            issue_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            blocks_q <= blocks_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
            issue_q  <= (state_q == ST_ISSUE);
        end
    end

    // Status captured on a completion; abort shares the vector so a
    // coincident abort lands in err_o alongside the datapath errors.
    always_comb begin
        status              = '0;
        status[ERR_CRC]     = crc_error_i;
        status[ERR_END_BIT] = end_bit_error_i;
        status[ERR_TIMEOUT] = timeout_error_i;
        status[ERR_ABORT]   = abort_i;
    end

    always_comb begin
        state_d  = state_q;
        blocks_d = blocks_q;
        err_d    = err_q;
        dir_d    = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dir_d    = dir_write_i;
                    blocks_d = block_count_i;
                    err_d    = '0;
                    state_d  = (block_count_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (transfer_complete_i) begin
                    err_d    = err_q | status;
                    blocks_d = blocks_q - 1'b1;
                    if ((status != '0) || (blocks_d == '0)) begin
                        state_d = ST_DONE;
                    end else if (stop_at_gap_i) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else if (abort_i) begin
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = ST_DRAIN;
                end
            end
            ST_PAUSED: begin
                if (abort_i) begin
                    err_d[ERR_ABORT] = 1'b1;
                    state_d          = ST_DONE;
                end else if (continue_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (transfer_complete_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The issue strobe is registered, landing two cycles after the event
    // that scheduled the block; it fires even if ISSUE is aborted so DRAIN
    // always has a completion to wait for.
    assign issue_read_o  = issue_q && !dir_q;
    assign issue_write_o = issue_q && dir_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign paused_o      = (state_q == ST_PAUSED);
    assign done_o        = (state_q == ST_DONE);
    assign blocks_left_o = blocks_q;
    assign err_o         = err_q;

`ifdef SD_XFER_TIMEOUT_EN
    sd_timeout_ctr u_timeout (
        .sdclk_i   (sdclk_i),
        .rst_dat_i (rst_dat_i),
        .start_i   (timeout_start_i),
        .clear_i   (timeout_clear_i),
        .limit_i   (timeout_cycles_i),
        .trigger_o (timeout_trigger_o)
    );
`else
    logic unused_timer;
    assign unused_timer      = ^{timeout_start_i, timeout_clear_i, timeout_cycles_i};
    assign timeout_trigger_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_xfer_ctrl.sv
// Self-checking bench for sd_xfer_ctrl: table of transfers scored through a
// queue, plus directed pause/abort/reset/timer sequences.
module tb_sd_xfer_ctrl;
    import sd_pkg::*;

    logic                 sdclk_i = 1'b0;
    logic                 rst_dat_i;
    logic                 start_i;
    logic                 dir_write_i;
    logic [15:0]          block_count_i;
    logic                 stop_at_gap_i;
    logic                 continue_i;
    logic                 abort_i;
    logic [TIMEOUT_W-1:0] timeout_cycles_i;
    logic                 issue_read_o;
    logic                 issue_write_o;
    logic                 transfer_complete_i;
    logic                 crc_error_i;
    logic                 end_bit_error_i;
    logic                 timeout_error_i;
    logic                 timeout_start_i;
    logic                 timeout_clear_i;
    logic                 timeout_trigger_o;
    logic                 busy_o;
    logic                 paused_o;
    logic                 done_o;
    logic [15:0]          blocks_left_o;
    logic [3:0]           err_o;

    typedef struct {
        logic       dir;
        int         count;
        int         err_kind;
        int         err_at;
        int         exp_issues;
        logic [3:0] exp_err;
        int         exp_left;
    } vec_t;

    typedef struct {
        logic [3:0] err;
        int         left;
        int         issues;
    } exp_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 sdclk_i = ~sdclk_i;

    sd_xfer_ctrl dut (
        .sdclk_i             (sdclk_i),
        .rst_dat_i           (rst_dat_i),
        .start_i             (start_i),
        .dir_write_i         (dir_write_i),
        .block_count_i       (block_count_i),
        .stop_at_gap_i       (stop_at_gap_i),
        .continue_i          (continue_i),
        .abort_i             (abort_i),
        .timeout_cycles_i    (timeout_cycles_i),
        .issue_read_o        (issue_read_o),
        .issue_write_o       (issue_write_o),
        .transfer_complete_i (transfer_complete_i),
        .crc_error_i         (crc_error_i),
        .end_bit_error_i     (end_bit_error_i),
        .timeout_error_i     (timeout_error_i),
        .timeout_start_i     (timeout_start_i),
        .timeout_clear_i     (timeout_clear_i),
        .timeout_trigger_o   (timeout_trigger_o),
        .busy_o              (busy_o),
        .paused_o            (paused_o),
        .done_o              (done_o),
        .blocks_left_o       (blocks_left_o),
        .err_o               (err_o)
    );

    task automatic tick();
        @(posedge sdclk_i);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (issue_read_o || issue_write_o) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int   issues;
        int   last_cmpl;
        int   cmpl_at;
        bit   fin;
        exp_t e;
        e.err = v.exp_err;
        e.left = v.exp_left;
        e.issues = v.exp_issues;
        sb_q.push_back(e);
        dir_write_i = v.dir;
        block_count_i = 16'(v.count);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        issues = 0;
        last_cmpl = -1;
        cmpl_at = -1;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            transfer_complete_i = 1'b0;
            crc_error_i = 1'b0;
            end_bit_error_i = 1'b0;
            timeout_error_i = 1'b0;
            if (issue_read_o || issue_write_o) begin
                issues++;
                check_output("issue_dir", int'(issue_write_o), int'(v.dir));
                if (last_cmpl >= 0) check_output("issue_gap", cyc - last_cmpl, 2);
                cmpl_at = cyc + 3;
            end
            if (done_o) begin
                fin = 1'b1;
                check_output("sb_depth", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_output("xfer_err", int'(err_o), int'(e.err));
                    check_output("xfer_left", int'(blocks_left_o), e.left);
                    check_output("xfer_issues", issues, e.issues);
                end
            end else if (cyc == cmpl_at) begin
                transfer_complete_i = 1'b1;
                if (issues == v.err_at) begin
                    case (v.err_kind)
                        1: crc_error_i = 1'b1;
                        2: end_bit_error_i = 1'b1;
                        3: timeout_error_i = 1'b1;
                        default: ;
                    endcase
                end
                last_cmpl = cyc;
            end
            tick();
        end
        transfer_complete_i = 1'b0;
        crc_error_i = 1'b0;
        end_bit_error_i = 1'b0;
        timeout_error_i = 1'b0;
        check_output("done_seen", int'(fin), 1);
        check_output("idle_after_done", int'(busy_o), 0);
        check_output("err_hold", int'(err_o), int'(v.exp_err));
        check_output("left_hold", int'(blocks_left_o), v.exp_left);
    endtask

`ifdef SD_XFER_TIMEOUT_EN
    task automatic timer_run(input bit clr_with_start, input int clr_at,
                             output int first, output int pulses);
        first = -1;
        pulses = 0;
        timeout_start_i = 1'b1;
        timeout_clear_i = clr_with_start;
        tick();
        timeout_start_i = 1'b0;
        timeout_clear_i = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if (timeout_trigger_o) begin
                pulses++;
                if (first < 0) first = k;
            end
            timeout_clear_i = (k == clr_at);
            tick();
        end
        timeout_clear_i = 1'b0;
    endtask
`endif

    initial begin
        bit ok;
        bit seen;
        int first;
        int pulses;

        rst_dat_i = 1'b1;
        start_i = 1'b0;
        dir_write_i = 1'b0;
        block_count_i = '0;
        stop_at_gap_i = 1'b0;
        continue_i = 1'b0;
        abort_i = 1'b0;
        timeout_cycles_i = 24'd5;
        transfer_complete_i = 1'b0;
        crc_error_i = 1'b0;
        end_bit_error_i = 1'b0;
        timeout_error_i = 1'b0;
        timeout_start_i = 1'b0;
        timeout_clear_i = 1'b0;

        vecs[0] = '{1'b0, 3, 0, 0, 3, 4'b0000, 0};
        vecs[1] = '{1'b1, 4, 1, 2, 2, 4'b0001, 2};
        vecs[2] = '{1'b1, 1, 0, 0, 1, 4'b0000, 0};
        vecs[3] = '{1'b0, 5, 3, 1, 1, 4'b0100, 4};
        vecs[4] = '{1'b0, 2, 2, 2, 2, 4'b0010, 0};

        tick();
        tick();
        check_output("rst_busy", int'(busy_o), 0);
        check_output("rst_done", int'(done_o), 0);
        check_output("rst_issue", int'(issue_read_o | issue_write_o), 0);
        check_output("rst_paused", int'(paused_o), 0);
        check_output("rst_left", int'(blocks_left_o), 0);
        check_output("rst_err", int'(err_o), 0);
        check_output("rst_trigger", int'(timeout_trigger_o), 0);
        rst_dat_i = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);

        // Pause at the block gap, then resume with continue_i.
        stop_at_gap_i = 1'b1;
        dir_write_i = 1'b0;
        block_count_i = 16'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_issue(ok);
        check_output("pause_first_issue", int'(ok), 1);
        tick();
        tick();
        transfer_complete_i = 1'b1;
        tick();
        transfer_complete_i = 1'b0;
        check_output("paused_set", int'(paused_o), 1);
        check_output("paused_left", int'(blocks_left_o), 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (issue_read_o || issue_write_o) seen = 1'b1;
            tick();
        end
        check_output("pause_no_issue", int'(seen), 0);
        check_output("pause_held", int'(paused_o), 1);
        continue_i = 1'b1;
        tick();
        continue_i = 1'b0;
        stop_at_gap_i = 1'b0;
        check_output("cont_issue_early", int'(issue_read_o), 0);
        tick();
        check_output("cont_issue", int'(issue_read_o), 1);
        check_output("cont_unpaused", int'(paused_o), 0);
        tick();
        tick();
        transfer_complete_i = 1'b1;
        tick();
        transfer_complete_i = 1'b0;
        check_output("pause_done", int'(done_o), 1);
        check_output("pause_left", int'(blocks_left_o), 0);
        check_output("pause_err", int'(err_o), 0);
        tick();

        // Abort while waiting: drain until the in-flight block completes.
        block_count_i = 16'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_issue(ok);
        check_output("abort_issue", int'(ok), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_output("drain_busy", int'(busy_o), 1);
        check_output("drain_err", int'(err_o), 8);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) seen = 1'b1;
            tick();
        end
        check_output("drain_no_done", int'(seen), 0);
        transfer_complete_i = 1'b1;
        tick();
        transfer_complete_i = 1'b0;
        check_output("drain_done", int'(done_o), 1);
        check_output("drain_err_final", int'(err_o), 8);
        tick();

        // Zero-length transfer finishes straight away and clears err_o.
        block_count_i = 16'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_output("zero_done", int'(done_o), 1);
        check_output("zero_issue", int'(issue_read_o | issue_write_o), 0);
        check_output("zero_err", int'(err_o), 0);
        tick();
        check_output("zero_idle", int'(busy_o), 0);

        // abort_i and continue_i are no-ops in IDLE.
        abort_i = 1'b1;
        continue_i = 1'b1;
        tick();
        abort_i = 1'b0;
        continue_i = 1'b0;
        tick();
        check_output("idle_abort_busy", int'(busy_o), 0);
        check_output("idle_abort_err", int'(err_o), 0);

        // Reset in the middle of a transfer.
        block_count_i = 16'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_issue(ok);
        check_output("rstmid_issue", int'(ok), 1);
        tick();
        rst_dat_i = 1'b1;
        #1;
        check_output("rstmid_busy", int'(busy_o), 0);
        check_output("rstmid_left", int'(blocks_left_o), 0);
        check_output("rstmid_err", int'(err_o), 0);
        check_output("rstmid_issue_low", int'(issue_read_o | issue_write_o), 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) seen = 1'b1;
            tick();
        end
        rst_dat_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) seen = 1'b1;
            tick();
        end
        check_output("rstmid_no_done", int'(seen), 0);
        check_output("rstmid_idle", int'(busy_o), 0);

`ifdef SD_XFER_TIMEOUT_EN
        timeout_cycles_i = 24'd5;
        timer_run(1'b0, -1, first, pulses);
        check_output("tmr_first", first, 6);
        check_output("tmr_pulses", pulses, 1);
        timer_run(1'b0, 3, first, pulses);
        check_output("tmr_cleared", pulses, 0);
        timer_run(1'b1, -1, first, pulses);
        check_output("tmr_rearm_first", first, 6);
        timeout_cycles_i = 24'd0;
        timer_run(1'b0, -1, first, pulses);
        check_output("tmr_zero_first", first, 1);
        check_output("tmr_zero_pulses", pulses, 1);
`else
        seen = 1'b0;
        timeout_start_i = 1'b1;
        tick();
        timeout_start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (timeout_trigger_o) seen = 1'b1;
            tick();
        end
        check_output("tmr_absent", int'(seen), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_xfer_ctrl.md
SD_XFER_CTRL -- requirements
Module: sd_xfer_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-002 SHALL provide these ports:
- sdclk_i  in  1  clock
- rst_dat_i  in  1  async active-high reset
- start_i  in  1  one-cycle pulse, begin transfer
- dir_write_i  in  1  1 = write, 0 = read; sampled with start_i
- block_count_i  in  16  blocks to move; sampled with start_i
- stop_at_gap_i  in  1  level, pause at next block boundary
- continue_i  in  1  pulse, resume from pause
- abort_i  in  1  pulse, end transfer early
- timeout_cycles_i  in  24  timeout limit in sdclk cycles
- issue_read_o / issue_write_o  out  1  one-cycle issue to DAT datapath
- transfer_complete_i, crc_error_i, end_bit_error_i, timeout_error_i  in  1  datapath completion and status
- timeout_start_i, timeout_clear_i  in  1  datapath timer control
- timeout_trigger_o  out  1  timer expiry pulse
- busy_o  out  1  not IDLE
- paused_o  out  1  in PAUSED
- done_o  out  1  one-cycle end-of-transfer pulse
- blocks_left_o  out  16  remaining blocks
- err_o  out  4  sticky {aborted, timeout, end_bit, crc}

Function
REQ-003 SHALL implement the states IDLE, ISSUE, WAIT, PAUSED, DRAIN and DONE.
REQ-004 IDLE: on start_i, latch dir and block_count, clear err_o; go to DONE if block_count_i == 0, otherwise go to ISSUE.
REQ-005 ISSUE: drive issue_write_o or issue_read_o for exactly one cycle, then go to WAIT.
REQ-006 WAIT: on transfer_complete_i, OR crc/end_bit/timeout errors into err_o and decrement blocks_left_o in the same cycle; then:
- go to DONE if any error, or if blocks_left reaches 0;
- otherwise go to PAUSED if stop_at_gap_i is high;
- otherwise go to ISSUE.
REQ-007 Next-block issue SHALL occur exactly 2 cycles after transfer_complete_i (complete -> ISSUE -> issue high).
REQ-008 PAUSED: continue_i SHALL go to ISSUE; abort_i SHALL set err_o[3] and go to DONE.
REQ-009 abort_i in ISSUE or WAIT SHALL set err_o[3] and go to DRAIN; DRAIN waits for transfer_complete_i, then goes to DONE.
REQ-010 abort_i SHALL be ignored in IDLE and DONE; start_i SHALL be ignored outside IDLE.
REQ-011 abort_i coincident with transfer_complete_i in WAIT SHALL go to DONE directly, with err_o[3] set and status ORed in.
REQ-012 DONE: pulse done_o for one cycle, then go to IDLE; err_o and blocks_left_o SHALL hold until the next start_i.
REQ-013 continue_i outside PAUSED SHALL be ignored.
REQ-014 Timer (when compiled in):
- timeout_start_i zeroes the counter and arms it;
- timeout_clear_i disarms it;
- start and clear in the same cycle re-arms (start wins);
- while armed, the counter increments each cycle;
- when counter == timeout_cycles_i, assert timeout_trigger_o for one cycle and disarm;
- timeout_cycles_i == 0 triggers the cycle after start.
REQ-015 The 24-bit timer counter SHALL saturate and never wrap.

Reset
REQ-016 Reset SHALL put the FSM in IDLE with all outputs 0, blocks_left_o = 0, err_o = 0, and the timer disarmed at 0.
REQ-017 Reset asserted mid-transfer SHALL abort immediately, with no done_o pulse.

Configuration
REQ-018 SHALL support macro SD_XFER_TIMEOUT_EN.
- Defined: the internal timer of REQ-014/015 is instantiated.
- Undefined: timeout_trigger_o is tied 0, timeout_start_i and timeout_clear_i are ignored, and no timer flops exist.

Structure
REQ-019 The FSM state enum, the err_o bit-index constants and a 24-bit timeout width constant SHALL live in shared package sd_pkg.
REQ-020 The timer SHALL be the sub-module sd_timeout_ctr, instantiated under SD_XFER_TIMEOUT_EN.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Read, block_count 3, clean completions -> three issue_read_o pulses, each 2 cycles after the previous complete; done_o after the 3rd; err_o = 0000.
- Write, block_count 4, crc_error_i with the 2nd complete -> only 2 issues; done_o; err_o = 0001; blocks_left_o = 2.
- stop_at_gap_i high, block_count 2 -> paused_o after the 1st complete; no issue until continue_i; then the 2nd issue follows 2 cycles after continue_i.
- abort_i in WAIT -> DRAIN; done_o only after transfer_complete_i; err_o = 1000.
- timeout_cycles_i = 5, timeout_start_i pulse -> timeout_trigger_o exactly 6 cycles later; clear at cycle 3 -> no trigger; simultaneous start and clear -> re-armed.
- block_count_i = 0 -> done_o 1 cycle after start_i, no issue; reset mid-WAIT -> all outputs 0, no done_o.
